// File: rtl/r_type_pkg.sv
// r_type_pkg: shared constants, field positions and FSM encoding for the R-type issue block.
package r_type_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] F_ADDU = 6'b001001;
  localparam logic [5:0] F_SUBU = 6'b001010;
  localparam logic [5:0] F_OR = 6'b010010;
  localparam logic [5:0] F_SRL = 6'b100010;
  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;
  localparam int FN_LSB = 0;
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;
  function automatic logic is_legal(input logic [31:0] w);
    logic [5:0] fn;
    fn = w[FN_LSB+:6];
    return w[OP_LSB+:6] == OP_RTYPE && (fn == F_ADDU || fn == F_SUBU || fn == F_OR || fn == F_SRL);
  endfunction
endpackage

// File: rtl/r_type_issue_reg_file.sv
// reg_file: 32x32 register file, three async read ports, one write port, R[0] never written.
module reg_file #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  output logic [31:0] dbg_data_o
);
  logic [31:0] mem_q [NREG];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      mem_q[wa_i] <= wd_i;
    end
  end
  assign rs_data_o = mem_q[rs_addr_i];
  assign rt_data_o = mem_q[rt_addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/r_type_issue.sv
// r_type_issue: four-state issue/execute/writeback engine for R-type ALU instructions.
module r_type_issue
  import r_type_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        ld_en,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] src_data,
  output logic [31:0] tar_data,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  input  logic [31:0] alu_result,
  output logic        done,
  output logic        illegal,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  state_e state_q, state_d;
  logic [31:0] instr_q, a_q, b_q, res_q, wb_data_q, rs_data, rt_data;
  logic [4:0] wb_addr_q, rd;
  logic done_q, illegal_q, legal, we;
  assign rd = instr_q[RD_LSB+:5];
  assign legal = is_legal(instr_q);
  // WB and preload never collide: preload is only honoured in IDLE.
  assign we = state_q == WB || (state_q == IDLE && ld_en);
  reg_file #(.NREG(NREG)) u_rf (
    .clk(clk),
    .rst(rst),
    .we_i(we),
    .wa_i(state_q == WB ? rd : ld_addr),
    .wd_i(state_q == WB ? res_q : ld_data),
    .rs_addr_i(instr_q[RS_LSB+:5]),
    .rt_addr_i(instr_q[RT_LSB+:5]),
    .dbg_addr_i(dbg_addr),
    .rs_data_o(rs_data),
    .rt_data_o(rt_data),
    .dbg_data_o(dbg_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (instr_valid ? READ : IDLE) :
              state_q == READ ? (legal ? EXEC : IDLE) :
              state_q == EXEC ? WB : IDLE;
  end
  always_comb begin
    instr_ready = state_q == IDLE;
    src_data = state_q == EXEC ? a_q : '0;
    tar_data = state_q == EXEC ? b_q : '0;
    shamt = state_q == EXEC ? instr_q[SH_LSB+:5] : '0;
    funct = state_q == EXEC ? instr_q[FN_LSB+:6] : '0;
    done = done_q;
    illegal = illegal_q;
    wb_addr = wb_addr_q;
    wb_data = wb_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      done_q <= 1'b0;
      illegal_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      if (state_q == IDLE && instr_valid) instr_q <= instr;
      if (state_q == READ) begin
        a_q <= rs_data;
        b_q <= rt_data;
      end
      if (state_q == EXEC) res_q <= alu_result;
      done_q <= state_q == WB;
      illegal_q <= state_q == READ && !legal;
      if (state_q == WB) begin
        wb_addr_q <= rd;
        wb_data_q <= res_q;
      end
    end
  end
endmodule

// File: tb/tb_r_type_issue.sv
// tb_r_type_issue: scoreboard bench with directed and random R-type traffic against a register-array model.
module tb_r_type_issue;
  localparam logic [5:0] ADDU = 6'b001001, SUBU = 6'b001010, ORF = 6'b010010, SRL = 6'b100010;
  logic clk = 0, rst = 1;
  logic instr_valid = 0, ld_en = 0;
  logic [31:0] instr = 0, ld_data = 0, alu_result, src_data, tar_data, wb_data, dbg_data;
  logic [4:0] ld_addr = 0, shamt, wb_addr, dbg_addr = 0;
  logic [5:0] funct;
  logic instr_ready, done, illegal;
  int n_cmp = 0, n_fail = 0, cyc = 0;
  logic [31:0] R [32];
  logic [4:0] last_a = 0;
  logic [31:0] last_d = 0;
  typedef struct {
    logic ill;
    logic [4:0] a;
    logic [31:0] d;
    int c;
  } exp_t;
  exp_t q[$];

  r_type_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .src_data(src_data), .tar_data(tar_data),
    .shamt(shamt), .funct(funct), .alu_result(alu_result), .done(done), .illegal(illegal),
    .wb_addr(wb_addr), .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External ALU the block drives.
  assign alu_result = funct == ADDU ? src_data + tar_data :
                      funct == SUBU ? src_data - tar_data :
                      funct == ORF ? (src_data | tar_data) :
                      funct == SRL ? src_data >> shamt : 32'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      last_a = 0;
      last_d = 0;
    end else if (done || illegal) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done, illegal}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {30'd0, done, illegal}, e.ill ? 32'd1 : 32'd2);
        chk("pulse_cycle", cyc, e.c);
        if (e.ill) begin
          chk("wb_addr_hold", {27'd0, wb_addr}, {27'd0, last_a});
          chk("wb_data_hold", wb_data, last_d);
        end else begin
          chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.a});
          chk("wb_data", wb_data, e.d);
          last_a = e.a;
          last_d = e.d;
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    wait_ready();
    ld_en = 1;
    ld_addr = a;
    ld_data = d;
    if (a != 0) R[a] = d;
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic dbg_chk(input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_R%0d", a), dbg_data, exp);
  endtask

  // Issue one word; optionally preload in the same cycle, optionally poke ld_en while busy.
  task automatic issue(input logic [31:0] w, input logic ld, input logic [4:0] la,
                       input logic [31:0] ldd, input logic noise);
    int k, busy;
    logic ok;
    logic [4:0] rs, rt, rd, sh;
    logic [5:0] fn;
    logic [31:0] a, b, r;
    wait_ready();
    instr = w;
    instr_valid = 1;
    ld_en = ld;
    ld_addr = la;
    ld_data = ldd;
    if (ld && la != 0) R[la] = ldd;
    rs = w[25:21];
    rt = w[20:16];
    rd = w[15:11];
    sh = w[10:6];
    fn = w[5:0];
    a = R[rs];
    b = R[rt];
    ok = w[31:26] == 0 && (fn == ADDU || fn == SUBU || fn == ORF || fn == SRL);
    r = fn == ADDU ? a + b : fn == SUBU ? a - b : fn == ORF ? (a | b) : a >> sh;
    k = cyc + 1;
    q.push_back('{!ok, rd, r, ok ? k + 3 : k + 1});
    if (ok && rd != 0) R[rd] = r;
    @(negedge clk);
    instr_valid = 0;
    ld_en = 0;
    busy = 0;
    while (!instr_ready && busy < 10) begin
      if (ok && cyc == k + 1) begin
        chk("exec_src", src_data, a);
        chk("exec_tar", tar_data, b);
        chk("exec_shamt", {27'd0, shamt}, {27'd0, sh});
        chk("exec_funct", {26'd0, funct}, {26'd0, fn});
      end else begin
        chk("idle_alu_side", {src_data | tar_data, shamt, funct}, '0);
      end
      busy++;
      if (noise) begin
        ld_en = $urandom_range(0, 1);
        ld_addr = 5'($urandom);
        ld_data = $urandom;
      end
      @(negedge clk);
    end
    ld_en = 0;
    chk("busy_cycles", busy, ok ? 3 : 1);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) R[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_pulses", {30'd0, done, illegal}, 32'd0);
    chk("rst_wb", {wb_addr, wb_data}, '0);
    chk("rst_alu_side", {src_data | tar_data, shamt, funct}, '0);
    rst = 0;
    @(negedge clk);
    dbg_chk(5'd7, 32'd0);
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    issue(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, ADDU), 0, 0, 0, 0);
    drain();
    dbg_chk(5'd3, 32'd8);
    preload(5'd1, 32'd3);
    preload(5'd2, 32'd5);
    issue(mk(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, SUBU), 0, 0, 0, 0);
    preload(5'd1, 32'hF0);
    preload(5'd2, 32'h0F);
    issue(mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, ORF), 0, 0, 0, 0);
    preload(5'd1, 32'h8000_0000);
    issue(mk(6'd0, 5'd1, 5'd2, 5'd5, 5'd31, SRL), 0, 0, 0, 0);
    issue(mk(6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'd0), 0, 0, 0, 0);
    issue(mk(6'b100011, 5'd1, 5'd2, 5'd8, 5'd0, ADDU), 0, 0, 0, 0);
    issue(mk(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, ADDU), 0, 0, 0, 0);
    issue(mk(6'd0, 5'd9, 5'd9, 5'd10, 5'd0, ADDU), 1, 5'd9, 32'h1234_5678, 0);
    preload(5'd0, 32'hFFFF_FFFF);
    drain();
    dbg_chk(5'd0, 32'd0);
    dbg_chk(5'd4, 32'hFFFF_FFFE);
    dbg_chk(5'd5, 32'd1);
    dbg_chk(5'd6, 32'hFF);
    dbg_chk(5'd10, 32'h2468_ACF0);
    // Abort an instruction in EXEC.
    preload(5'd1, 32'd7);
    wait_ready();
    instr = mk(6'd0, 5'd1, 5'd1, 5'd11, 5'd0, ADDU);
    instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    chk("pre_abort_funct", {26'd0, funct}, {26'd0, ADDU});
    rst = 1;
    #1;
    chk("abort_outputs", {src_data | tar_data | wb_data, shamt, funct, wb_addr, done, illegal}, '0);
    for (int i = 0; i < 32; i++) R[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    repeat (4) @(negedge clk);
    dbg_chk(5'd11, 32'd0);
    dbg_chk(5'd1, 32'd0);
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      int p;
      for (int j = $urandom_range(0, 2); j > 0; j--) preload(5'($urandom), $urandom);
      op = $urandom_range(0, 7) == 0 ? 6'($urandom) : 6'd0;
      p = $urandom_range(0, 4);
      fn = p == 0 ? ADDU : p == 1 ? SUBU : p == 2 ? ORF : p == 3 ? SRL : 6'($urandom);
      issue(mk(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn),
            $urandom_range(0, 3) == 0, 5'($urandom), $urandom, 1);
    end
    drain();
    for (int i = 0; i < 32; i++) dbg_chk(5'(i), R[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/r_type_issue.md
R_TYPE_ISSUE -- requirements
Module: r_type_issue

Interface
REQ-001 SHALL have parameter NREG, default 32, the number of architectural registers (fixed at 32; 5-bit addresses).
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr  in  32  R-type word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- instr_ready  out  1  block can accept an instruction.
- ld_en  in  1  register preload strobe.
- ld_addr  in  5  preload address.
- ld_data  in  32  preload data.
- src_data  out  32  ALU operand A, equal to R[rs].
- tar_data  out  32  ALU operand B, equal to R[rt].
- shamt  out  5  ALU shift amount.
- funct  out  6  ALU operation select.
- alu_result  in  32  combinational ALU result.
- done  out  1  one-cycle pulse: instruction retired.
- illegal  out  1  one-cycle pulse: instruction rejected.
- wb_addr  out  5  retired destination register.
- wb_data  out  32  retired result.
- dbg_addr  in  5  debug read address.
- dbg_data  out  32  combinational R[dbg_addr].

Function
REQ-003 SHALL recognise funct codes ADDU 6'b001001, SUBU 6'b001010, OR 6'b010010, SRL 6'b100010; the ALU computes A+B, A-B, A|B, and A>>shamt respectively.
REQ-004 SHALL implement FSM states IDLE, READ, EXEC, WB; instr_ready=1 only in IDLE.
REQ-005 Handshake: accept on the edge where instr_valid&&instr_ready; latch instr; IDLE->READ.
REQ-006 READ: latch R[rs] and R[rt] into the operand registers; if opcode!=0 or funct is not in REQ-003, pulse illegal in the next cycle and go to IDLE; else go to EXEC.
REQ-007 EXEC: drive src_data, tar_data, shamt, funct from the registers; capture alu_result at the closing edge; EXEC->WB.
REQ-008 WB: write the result to R[rd] unless rd==0; pulse done with wb_addr=rd and wb_data=result; WB->IDLE.
REQ-009 Latency: accepted at edge k -> done high in the cycle after edge k+3; throughput is 1 instruction per 4 cycles.
REQ-010 Outside EXEC, src_data, tar_data, shamt, and funct SHALL be 0.
REQ-011 R[0] SHALL always read 0; writes to R[0] by WB or preload SHALL be discarded; done still pulses for rd==0.
REQ-012 ld_en SHALL be honoured only in IDLE and ignored elsewhere; a simultaneous ld_en and accept applies both, and READ sees the preloaded value.
REQ-013 wb_addr and wb_data SHALL hold their last retired values between done pulses.
REQ-014 Arithmetic SHALL wrap modulo 2^32; there is no overflow or trap.

Reset
REQ-015 On rst: state=IDLE, all registers R[0..31]=0, done=0, illegal=0, wb_addr=0, wb_data=0, and ALU-side outputs=0.
REQ-016 Reset asserted mid-instruction SHALL abort it with no register write and no done pulse; instr_ready=1 in the first cycle after deassertion.

Structure
REQ-017 Package r_type_pkg SHALL hold the funct constants, the opcode constant 0, the FSM state enum, and the field bit positions.
REQ-018 The register file SHALL be the sub-module reg_file: 32x32, read ports rs/rt/dbg, one write port, R[0] hardwired to 0, asynchronous reset.

Verification
REQ-019 Preload R1=5, R2=3; issue ADDU rd=3 rs=1 rt=2 -> done at k+4, wb_addr=3, wb_data=8, dbg R3=8.
REQ-020 R1=3, R2=5; SUBU rd=4 rs=1 rt=2 -> wb_data=32'hFFFF_FFFE; OR of 32'hF0 and 32'h0F -> 32'hFF.
REQ-021 R1=32'h8000_0000; SRL rd=5 rs=1 shamt=31 -> wb_data=1; during EXEC, funct=6'b100010 and shamt=31.
REQ-022 funct=6'b000000, or opcode=6'b100011 -> illegal pulse, no done, and all registers unchanged.
REQ-023 ADDU rd=0 -> done pulses, dbg R0=0; instr_valid held high -> instr_ready low for 3 cycles between accepts.
REQ-024 Assert rst during EXEC -> no done, R[rd] unchanged (0), all outputs 0, and IDLE is resumed.
